// File: rtl/divby3_ctrl.sv
// Sequencer for a serial MSB-first mod-3 checker: accept word, clear checker, shift WIDTH bits, sample verdict.
// Latency WIDTH+2 edges accept-to-result; result held until m_ready, no new word accepted until then.
module divby3_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             chk_rstn,
    output logic             chk_in,
    input  logic             chk_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_div3,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic [CNT_W-1:0] div3_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             rstn_q, rstn_d;
    logic             vld_q, vld_d;
    logic             div3_q, div3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        bit_d   = bit_q;
        rstn_d  = 1'b1;
        vld_d   = vld_q;
        div3_d  = div3_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    shift_d = s_data;
                    data_d  = s_data;
                    bit_d   = BW'(WIDTH - 1);
                    rstn_d  = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_d = shift_q << 1;
                bit_d   = bit_q - 1'b1;
                if (bit_q == '0) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // checker has now consumed every bit; its verdict is valid only here
                div3_d = chk_out;
                vld_d  = 1'b1;
                if (chk_out && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (m_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            rstn_q  <= 1'b0;
            vld_q   <= 1'b0;
            div3_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            rstn_q  <= rstn_d;
            vld_q   <= vld_d;
            div3_q  <= div3_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_ready  = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign chk_in   = (state_q == ST_SHIFT) & shift_q[WIDTH-1];
    assign chk_rstn = rstn_q;
    assign m_valid  = vld_q;
    assign m_div3   = div3_q;
    assign m_data   = data_q;
    assign div3_cnt = cnt_q;

endmodule

// File: tb/tb_divby3_ctrl.sv
// Bench for divby3_ctrl: three builds (8/16, 8/2, 1/16), each driving a behavioural mod-3 checker.
module tb_divby3_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m3(input logic [1:0] r, input logic b);
        return 2'(({2'b00, r, b}) % 3);
    endfunction

    // ---------------- build A: WIDTH=8, CNT_W=16
    logic        a_s_valid, a_s_ready, a_chk_rstn, a_chk_in, a_chk_out;
    logic        a_m_valid, a_m_ready, a_m_div3, a_busy;
    logic [7:0]  a_s_data, a_m_data;
    logic [15:0] a_cnt;
    logic [1:0]  a_r;

    divby3_ctrl #(.WIDTH(8), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .chk_rstn(a_chk_rstn), .chk_in(a_chk_in), .chk_out(a_chk_out),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_div3(a_m_div3), .m_data(a_m_data),
        .busy(a_busy), .div3_cnt(a_cnt)
    );

    always @(posedge clk or negedge a_chk_rstn)
        if (!a_chk_rstn) a_r <= 2'd0;
        else             a_r <= m3(a_r, a_chk_in);
    assign a_chk_out = (a_r == 2'd0);

    // ---------------- build B: WIDTH=8, CNT_W=2 ; build C: WIDTH=1
    logic       b_s_valid, b_s_ready, b_chk_rstn, b_chk_in, b_chk_out;
    logic       b_m_valid, b_m_div3, b_busy;
    logic [7:0] b_m_data;
    logic [1:0] b_cnt, b_r;
    logic       c_s_valid, c_s_ready, c_chk_rstn, c_chk_in, c_chk_out;
    logic       c_m_valid, c_m_div3, c_busy;
    logic [0:0] c_s_data, c_m_data;
    logic [15:0] c_cnt;
    logic [1:0] c_r;

    int         bc_sel = 1;
    logic       bc_sv = 1'b0;
    logic [7:0] bc_d = 8'h00;

    assign b_s_valid = bc_sv && (bc_sel == 1);
    assign c_s_valid = bc_sv && (bc_sel == 2);
    assign c_s_data  = bc_d[0];

    divby3_ctrl #(.WIDTH(8), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(bc_d),
        .chk_rstn(b_chk_rstn), .chk_in(b_chk_in), .chk_out(b_chk_out),
        .m_valid(b_m_valid), .m_ready(1'b1), .m_div3(b_m_div3), .m_data(b_m_data),
        .busy(b_busy), .div3_cnt(b_cnt)
    );

    divby3_ctrl #(.WIDTH(1), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
        .chk_rstn(c_chk_rstn), .chk_in(c_chk_in), .chk_out(c_chk_out),
        .m_valid(c_m_valid), .m_ready(1'b1), .m_div3(c_m_div3), .m_data(c_m_data),
        .busy(c_busy), .div3_cnt(c_cnt)
    );

    always @(posedge clk or negedge b_chk_rstn)
        if (!b_chk_rstn) b_r <= 2'd0;
        else             b_r <= m3(b_r, b_chk_in);
    assign b_chk_out = (b_r == 2'd0);

    always @(posedge clk or negedge c_chk_rstn)
        if (!c_chk_rstn) c_r <= 2'd0;
        else             c_r <= m3(c_r, c_chk_in);
    assign c_chk_out = (c_r == 2'd0);

    logic       bc_rdy, bc_vld, bc_div3;
    logic [7:0] bc_mdat;
    assign bc_rdy  = (bc_sel == 1) ? b_s_ready : c_s_ready;
    assign bc_vld  = (bc_sel == 1) ? b_m_valid : c_m_valid;
    assign bc_div3 = (bc_sel == 1) ? b_m_div3  : c_m_div3;
    assign bc_mdat = (bc_sel == 1) ? b_m_data  : {7'd0, c_m_data};

    // ---------------- scoreboard
    typedef struct {
        logic [7:0] data;
        logic       div3;
        int         acc;
    } exp_t;

    exp_t qa[$];
    exp_t qbc[$];

    task automatic send_a(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (!a_s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("a_s_ready_wait", a_s_ready, 1);
        a_s_valid = 1'b1;
        a_s_data  = d;
        qa.push_back('{d, (d % 3) == 0, cyc + 1});
        @(negedge clk);
        a_s_valid = 1'b0;
    endtask

    task automatic drain_a();
        int t = 0;
        while ((qa.size() != 0 || a_busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("a_drain", qa.size(), 0);
    endtask

    // Monitor for A: clear-pulse length, serial bit order, latency, counter, result contents.
    logic       a_prev_vld = 1'b0;
    int         a_lowlen = 0;
    bit         a_armed = 1'b0;
    int         a_idx = 0;
    logic [7:0] a_bits = 8'h00;
    int         a_expcnt = 0;

    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            a_armed    = 1'b0;
            a_lowlen   = 0;
            a_prev_vld = 1'b0;
            a_expcnt   = 0;
        end else begin
            if (!a_chk_rstn && a_busy) begin
                a_lowlen++;
                a_armed = 1'b1;
                a_idx   = 0;
            end else if (a_armed) begin
                if (a_lowlen != 0) begin
                    check("a_clr_len", a_lowlen, 1);
                    a_lowlen = 0;
                end
                a_bits = {a_bits[6:0], a_chk_in};
                a_idx++;
                if (a_idx == 8) begin
                    a_armed = 1'b0;
                    if (qa.size() != 0) check("a_chk_in_seq", a_bits, qa[0].data);
                end
            end
            if (a_m_valid && !a_prev_vld) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_vld", 1, 0);
                end else begin
                    check("a_latency", cyc - qa[0].acc, 10);
                    if (qa[0].div3 && a_expcnt < 65535) a_expcnt++;
                    check("a_div3_cnt", a_cnt, a_expcnt);
                end
            end
            if (a_m_valid && a_m_ready && qa.size() != 0) begin
                e = qa.pop_front();
                check("a_m_div3", a_m_div3, e.div3);
                check("a_m_data", a_m_data, e.data);
            end
            a_prev_vld = a_m_valid;
        end
    end

    int b_expcnt = 0;

    task automatic run_bc(input int sel, input logic [7:0] d);
        int   t = 0;
        int   w;
        exp_t e;
        logic [7:0] v;
        w = (sel == 1) ? 8 : 1;
        v = (sel == 1) ? d : {7'd0, d[0]};
        bc_sel = sel;
        @(negedge clk);
        while (!bc_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bc_s_ready_wait", bc_rdy, 1);
        bc_sv = 1'b1;
        bc_d  = v;
        qbc.push_back('{v, (v % 3) == 0, cyc + 1});
        @(negedge clk);
        bc_sv = 1'b0;
        t = 0;
        while (!bc_vld && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bc_m_valid_seen", bc_vld, 1);
        e = qbc.pop_front();
        check("bc_latency", cyc - e.acc, w + 2);
        check("bc_m_div3", bc_div3, e.div3);
        check("bc_m_data", bc_mdat, e.data);
        if (sel == 1) begin
            if (e.div3 && b_expcnt < 3) b_expcnt++;
            check("b_div3_cnt_sat", b_cnt, b_expcnt);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        a_s_valid = 1'b0;
        a_s_data  = 8'h00;
        a_m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_s_ready", a_s_ready, 1);
        check("rst_m_valid", a_m_valid, 0);
        check("rst_m_div3", a_m_div3, 0);
        check("rst_m_data", a_m_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_chk_in", a_chk_in, 0);
        check("rst_chk_rstn", a_chk_rstn, 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("chk_rstn_before_edge", a_chk_rstn, 0);
        @(negedge clk);
        #1;
        check("chk_rstn_after_edge", a_chk_rstn, 1);

        // back-to-back words
        send_a(8'h00);
        send_a(8'h03);
        send_a(8'h07);
        drain_a();
        check("cnt_after_three", a_cnt, 2);

        send_a(8'hFF);
        send_a(8'h80);
        drain_a();

        // downstream stall: result held, new words refused
        a_m_ready = 1'b0;
        send_a(8'h96);
        begin
            int t = 0;
            while (!a_m_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        check("hold_vld_seen", a_m_valid, 1);
        repeat (5) begin
            @(negedge clk);
            a_s_valid = ~a_s_valid;
            a_s_data  = 8'h33;
            #1;
            check("hold_m_valid", a_m_valid, 1);
            check("hold_m_div3", a_m_div3, 1);
            check("hold_m_data", a_m_data, 8'h96);
            check("hold_s_ready", a_s_ready, 0);
        end
        @(negedge clk);
        a_s_valid = 1'b0;
        a_m_ready = 1'b1;
        @(negedge clk);
        #1;
        check("idle_after_hs_ready", a_s_ready, 1);
        check("idle_after_hs_busy", a_busy, 0);
        check("cnt_after_hold", a_cnt, 4);

        // reset during the 4th SHIFT cycle
        send_a(8'h09);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_m_valid", a_m_valid, 0);
        check("midrst_cnt", a_cnt, 0);
        check("midrst_chk_rstn", a_chk_rstn, 0);
        check("midrst_s_ready", a_s_ready, 1);
        @(negedge clk);
        #1;
        check("midrst_chk_rstn_hold", a_chk_rstn, 0);
        @(negedge clk);
        rst = 1'b0;
        qa.delete();
        send_a(8'h06);
        drain_a();
        check("cnt_after_rst", a_cnt, 1);

        // saturating counter build
        run_bc(1, 8'h03);
        run_bc(1, 8'h06);
        run_bc(1, 8'h09);
        run_bc(1, 8'h0C);

        // single-bit build
        run_bc(2, 8'h01);
        run_bc(2, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
